// File: rtl/key_display_pkg.sv
// rtl/key_display_pkg.sv - shared types and constants for the two-digit key display
// Purpose: refresh FSM state encoding, digit width and key FIFO depth.
// Ports: none (package).
package key_display_pkg;

    typedef enum logic [1:0] {
        SHOW0 = 2'd0,
        DEAD0 = 2'd1,
        SHOW1 = 2'd2,
        DEAD1 = 2'd3
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - two-entry FIFO buffering pending key codes
// Purpose: holds key events until the display controller commits them.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   push, din       - write request and key code
//   pop, dout       - read request and oldest stored code
//   count           - number of stored entries (0..2)
//   full, empty     - occupancy flags
//   drop            - push refused because the FIFO was full with no pop
module key_fifo
    import key_display_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout,
    output logic [1:0]         count,
    output logic               full,
    output logic               empty,
    output logic               drop
);

    logic [DIGIT_W-1:0] mem_q [FIFO_DEPTH];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q;
    logic               do_push;
    logic               do_pop;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'(FIFO_DEPTH));
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // only refused when nothing is leaving.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/key_display_ctrl.sv
// rtl/key_display_ctrl.sv - multiplexed two-digit display of the last two key codes
// Purpose: time-multiplexes one shared seven-segment decoder across two digits
// with dark gaps between slots, committing buffered key events only in gaps.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   key_valid, key_code   - one-cycle pulse with a new debounced key code
//   hex_sel               - value for the shared seven-segment decoder
//   anode                 - active-low digit enables (bit0 right/newest)
//   digit_new, digit_old  - committed newest and previous digits
//   fifo_count            - pending uncommitted key events
//   overflow              - sticky, set when a key event was dropped
module key_display_ctrl
    import key_display_pkg::*;
#(
    parameter int REFRESH_CYCLES = 24000,
    parameter int DEAD_CYCLES    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_code,
    output logic [DIGIT_W-1:0] hex_sel,
    output logic [1:0]         anode,
    output logic [DIGIT_W-1:0] digit_new,
    output logic [DIGIT_W-1:0] digit_old,
    output logic [1:0]         fifo_count,
    output logic               overflow
);

    localparam int CNT_MAX = (REFRESH_CYCLES > DEAD_CYCLES) ? REFRESH_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIGIT_W-1:0] digit_new_q, digit_new_d;
    logic [DIGIT_W-1:0] digit_old_q, digit_old_d;
    logic [DIGIT_W-1:0] hex_sel_q, hex_sel_d;
    logic [1:0]         anode_q, anode_d;
    logic               overflow_q, overflow_d;

    logic               first_dead;
    logic               pop;
    logic [DIGIT_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_drop;

    key_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (key_valid),
        .pop   (pop),
        .din   (key_code),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    // The counter is reloaded on entry, so a freshly entered DEAD state still
    // holds DEAD_LOAD during its first cycle: that is the only commit slot.
    assign first_dead = ((state_q == DEAD0) || (state_q == DEAD1)) && (cnt_q == DEAD_LOAD);
    assign pop        = first_dead && !fifo_empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
            case (state_q)
                SHOW0:   state_d = DEAD0;
                DEAD0:   state_d = SHOW1;
                SHOW1:   state_d = DEAD1;
                default: state_d = SHOW0;
            endcase
            cnt_d = ((state_d == SHOW0) || (state_d == SHOW1)) ? SHOW_LOAD : DEAD_LOAD;
        end

        digit_new_d = pop ? fifo_dout   : digit_new_q;
        digit_old_d = pop ? digit_new_q : digit_old_q;

        case (state_d)
            SHOW0:   anode_d = 2'b10;
            SHOW1:   anode_d = 2'b01;
            default: anode_d = 2'b11;
        endcase

        // Each DEAD state already presents the digit lit in the following
        // SHOW state, giving the decoder a dark interval to settle.
        hex_sel_d = ((state_d == SHOW0) || (state_d == DEAD1)) ? digit_new_d : digit_old_d;

        overflow_d = overflow_q | (fifo_drop & fifo_full);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DEAD1;
            cnt_q       <= DEAD_LOAD;
            digit_new_q <= '0;
            digit_old_q <= '0;
            hex_sel_q   <= '0;
            anode_q     <= 2'b11;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
            hex_sel_q   <= hex_sel_d;
            anode_q     <= anode_d;
            overflow_q  <= overflow_d;
        end
    end

    assign hex_sel   = hex_sel_q;
    assign anode     = anode_q;
    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/key_display_ctrl.md
KEY_DISPLAY_CTRL -- requirements
Module: key_display_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 24000, cycles each digit is lit per refresh slot (minimum 2).
REQ-002 SHALL have parameter DEAD_CYCLES, default 4, cycles both digits are dark between slots (minimum 1).
REQ-003 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port key_valid, input, 1, one-cycle pulse marking a new debounced key code.
REQ-006 SHALL have port key_code, input, 4, hex value of the key; sampled only when key_valid=1.
REQ-007 SHALL have port hex_sel, output, 4, digit value driven to the single shared seven-segment decoder.
REQ-008 SHALL have port anode, output, 2, active-low digit enables; bit0 is the right (newest) digit and bit1 the left (older) digit.
REQ-009 SHALL have port digit_new, output, 4, committed newest digit.
REQ-010 SHALL have port digit_old, output, 4, committed previous digit.
REQ-011 SHALL have port fifo_count, output, 2, number of pending uncommitted key events (0..2).
REQ-012 SHALL have port overflow, output, 1, sticky flag; set when a key event is dropped.

Function
REQ-013 SHALL run a 4-state FSM: SHOW0 -> DEAD0 -> SHOW1 -> DEAD1 -> SHOW0, cycling forever.
REQ-014 SHALL hold each SHOW state for exactly REFRESH_CYCLES cycles and each DEAD state for exactly DEAD_CYCLES cycles, using one shared down-counter reloaded on every state change.
REQ-015 SHALL drive anode: SHOW0=2'b10; SHOW1=2'b01; DEAD0 and DEAD1=2'b11. The anode value SHALL never have both bits low.
REQ-016 SHALL drive hex_sel: digit_new in SHOW0 and DEAD1; digit_old in SHOW1 and DEAD0. The decoder input therefore settles before its digit is lit.
REQ-017 SHALL buffer key events in a 2-entry FIFO.
REQ-018 A key_valid pulse SHALL be written into the FIFO at the same clock edge that samples it, and fifo_count SHALL increment that cycle.
REQ-019 SHALL commit digits only on the first cycle of DEAD0 or DEAD1, and only when the FIFO is non-empty. A commit pops one entry, loads digit_old<=digit_new and digit_new<=popped code.
REQ-020 SHALL commit at most one event per DEAD state. A second pending event SHALL wait for the next DEAD state.
REQ-021 SHALL bypass nothing: a key arriving on a commit cycle with an empty FIFO is stored and committed at the next DEAD entry.
REQ-022 Push and pop in the same cycle when the FIFO is full: the pop SHALL free a slot, the push SHALL be accepted, and fifo_count SHALL stay 2.
REQ-023 Push when the FIFO is full with no pop: the event SHALL be dropped, the FIFO contents SHALL be unchanged, and overflow SHALL be set.
REQ-024 Push and pop in the same cycle with 1 entry: fifo_count SHALL stay 1, holding the new code.
REQ-025 FIFO order SHALL be first-in first-out. Read and write pointers SHALL be 1 bit wide and wrap 1->0.
REQ-026 A key event SHALL appear on digit_new no later than REFRESH_CYCLES+DEAD_CYCLES+1 cycles after key_valid when the FIFO was empty.
REQ-027 overflow SHALL remain set until reset.

Reset
REQ-028 While reset=1, asynchronously and regardless of clk: state=DEAD1, counter loaded with DEAD_CYCLES-1, anode=2'b11, hex_sel=0, digit_new=0, digit_old=0, fifo_count=0, overflow=0, FIFO pointers=0.
REQ-029 Reset asserted mid-operation SHALL discard pending FIFO entries and uncommitted events.
REQ-030 After reset deasserts, the first SHOW0 SHALL begin exactly DEAD_CYCLES cycles later.
REQ-031 key_valid asserted while reset=1 SHALL be ignored.

Structure
REQ-032 Package key_display_pkg SHALL hold the FSM state enum (SHOW0, DEAD0, SHOW1, DEAD1), the digit width constant (4), and the FIFO depth constant (2).
REQ-033 The FIFO SHALL be a sub-module named key_fifo. It has ports push, pop, din, dout, count, full, empty, and drop; the controller owns the FSM, the counter and the digit registers.
REQ-034 The counter width SHALL be $clog2 of the larger of REFRESH_CYCLES and DEAD_CYCLES.

Verification (bench uses REFRESH_CYCLES=8, DEAD_CYCLES=2)
REQ-035 Reset release, no keys -> anode sequence 11,11 then 10 for 8 cycles, 11 for 2 cycles, 01 for 8 cycles, repeating; hex_sel=0 throughout.
REQ-036 Single key 4'hA during SHOW0 -> fifo_count=1 next cycle; at DEAD0 entry digit_new=A, digit_old=0, fifo_count=0; hex_sel=A during the next SHOW0.
REQ-037 Keys 1,2,3 pulsed on consecutive cycles within one SHOW slot -> 3 is dropped and overflow=1; at the next two DEAD entries the commits are 1 then 2, ending with digit_old=1, digit_new=2.
REQ-038 FIFO full (5,6) and key 7 on the first cycle of DEAD0 -> 5 commits, 7 is accepted, fifo_count stays 2, overflow stays 0.
REQ-039 Reset pulsed for 1 cycle while fifo_count=2 in SHOW1 -> all outputs return to reset values immediately; pending keys are never committed.
